// File: rtl/mem_masked_sync_rd.sv
// mem_masked_sync_rd
// Single-clock scratch RAM. It supports per-lane write masking and a registered
// read with a valid strobe. A same-address read-during-write can optionally
// bypass the new write data. A clear sequencer zeroes every entry after reset
// or on request, and the block reports busy while that sweep runs.
module mem_masked_sync_rd #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int LANES  = 2,
    parameter bit BYPASS = 1'b1,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_wrEna,
    input  logic [LANES-1:0]  io_wrMask,
    input  logic [ADDR_W-1:0] io_wrAddr,
    input  logic [DATA_W-1:0] io_wrData,
    input  logic              io_rdEna,
    input  logic [ADDR_W-1:0] io_rdAddr,
    output logic [DATA_W-1:0] io_rdData,
    output logic              io_rdValid,
    input  logic              io_clrReq,
    output logic              io_busy
);

    localparam int LANE_W = DATA_W / LANES;

    localparam logic [0:0] ST_CLR  = 1'b0;
    localparam logic [0:0] ST_IDLE = 1'b1;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word;
    logic              idle;

    assign idle    = (state == ST_IDLE);
    assign io_busy = (state == ST_CLR);

    // Sequencer: sweep every entry once, then idle until a clear is requested
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_CLR;
            clr_ptr <= '0;
        end else if (state == ST_CLR) begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
            if (clr_ptr == LAST_PTR) begin
                state <= ST_IDLE;
            end
        end else if (io_clrReq) begin
            state   <= ST_CLR;
            clr_ptr <= '0;
        end
    end

    // Array update: the sweep owns the array while clearing, otherwise masked lane writes
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == ST_CLR) begin
                mem[clr_ptr] <= '0;
            end else if (io_wrEna) begin
                for (int i = 0; i < LANES; i++) begin
                    if (io_wrMask[i]) begin
                        mem[io_wrAddr][i*LANE_W +: LANE_W] <= io_wrData[i*LANE_W +: LANE_W];
                    end
                end
            end
        end
    end

    // Read word: old contents, with written lanes replaced when bypass is enabled
    always_comb begin
        rd_word = mem[io_rdAddr];
        if (BYPASS && io_wrEna && (io_wrAddr == io_rdAddr)) begin
            for (int i = 0; i < LANES; i++) begin
                if (io_wrMask[i]) begin
                    rd_word[i*LANE_W +: LANE_W] = io_wrData[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Registered read port: data is captured on an accepted read and held otherwise
    always_ff @(posedge clock) begin
        if (reset) begin
            io_rdValid <= 1'b0;
            io_rdData  <= '0;
        end else if (idle && io_rdEna) begin
            io_rdValid <= 1'b1;
            io_rdData  <= rd_word;
        end else begin
            io_rdValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_masked_sync_rd.sv
// tb_mem_masked_sync_rd
// Randomized and directed stimulus for mem_masked_sync_rd. A word-level
// reference model is compared against the DUT on every cycle. Literal
// expectations also pin down the headline behaviours.
module tb_mem_masked_sync_rd;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int LANES  = 2;
    localparam int ADDR_W = 4;
    localparam int LANE_W = DATA_W / LANES;
    localparam bit BYPASS = 1'b1;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              io_wrEna = 1'b0;
    logic [LANES-1:0]  io_wrMask = '0;
    logic [ADDR_W-1:0] io_wrAddr = '0;
    logic [DATA_W-1:0] io_wrData = '0;
    logic              io_rdEna = 1'b0;
    logic [ADDR_W-1:0] io_rdAddr = '0;
    logic [DATA_W-1:0] io_rdData;
    logic              io_rdValid;
    logic              io_clrReq = 1'b0;
    logic              io_busy;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    mem_masked_sync_rd #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .LANES (LANES),
        .BYPASS(BYPASS)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .io_wrEna  (io_wrEna),
        .io_wrMask (io_wrMask),
        .io_wrAddr (io_wrAddr),
        .io_wrData (io_wrData),
        .io_rdEna  (io_rdEna),
        .io_rdAddr (io_rdAddr),
        .io_rdData (io_rdData),
        .io_rdValid(io_rdValid),
        .io_clrReq (io_clrReq),
        .io_busy   (io_busy)
    );

    // Reference model state
    logic [DATA_W-1:0] model_mem [DEPTH];
    int                busy_left = 0;
    logic              exp_valid = 1'b0;
    logic [DATA_W-1:0] exp_data = '0;
    bit                model_ready = 1'b0;
    logic [DATA_W-1:0] m_bm;
    logic [DATA_W-1:0] m_rd;

    function automatic logic [DATA_W-1:0] lane_bits(input logic [LANES-1:0] mask);
        logic [DATA_W-1:0] bm;
        bm = '0;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i]) bm = bm | (DATA_W'((1 << LANE_W) - 1) << (i * LANE_W));
        end
        return bm;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: the whole array is treated as zero once a clear starts, because nothing can touch it until the sweep ends
    always @(posedge clock) begin
        if (reset) begin
            model_ready = 1'b1;
            busy_left   = DEPTH;
            exp_valid   = 1'b0;
            exp_data    = '0;
            for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;
        end else if (busy_left > 0) begin
            busy_left--;
            exp_valid = 1'b0;
        end else begin
            m_bm = io_wrEna ? lane_bits(io_wrMask) : '0;
            m_rd = model_mem[io_rdAddr];
            if (BYPASS && io_wrAddr == io_rdAddr) m_rd = (m_rd & ~m_bm) | (io_wrData & m_bm);
            exp_valid = io_rdEna;
            if (io_rdEna) exp_data = m_rd;
            model_mem[io_wrAddr] = (model_mem[io_wrAddr] & ~m_bm) | (io_wrData & m_bm);
            if (io_clrReq) begin
                busy_left = DEPTH;
                for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;
            end
        end
    end

    // Compare process: every output is checked against the model on each falling edge
    always @(negedge clock) begin
        if (model_ready) begin
            check_output("rd_valid", 32'(io_rdValid), 32'(exp_valid));
            check_output("rd_data", 32'(io_rdData), 32'(exp_data));
            check_output("busy", 32'(io_busy), 32'(busy_left > 0));
        end
    end

    task automatic apply_stimulus(input logic we, input logic [LANES-1:0] mask,
                                  input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                                  input logic re, input logic [ADDR_W-1:0] ra, input logic clr);
        @(negedge clock);
        io_wrEna  = we;
        io_wrMask = mask;
        io_wrAddr = wa;
        io_wrData = wd;
        io_rdEna  = re;
        io_rdAddr = ra;
        io_clrReq = clr;
    endtask

    task automatic apply_idle();
        apply_stimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic apply_random(input int clr_odds);
        logic [ADDR_W-1:0] wa;
        wa = ADDR_W'($urandom_range(0, DEPTH - 1));
        apply_stimulus(1'($urandom), LANES'($urandom), wa, DATA_W'($urandom), 1'($urandom),
                       ($urandom_range(0, 2) == 0) ? wa : ADDR_W'($urandom_range(0, DEPTH - 1)),
                       (clr_odds > 0) && ($urandom_range(0, clr_odds - 1) == 0));
    endtask

    task automatic wait_busy_done(output int n);
        n = 0;
        while (io_busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clock);
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) apply_stimulus(1'b0, '0, '0, '0, 1'b1, ADDR_W'(a), 1'b0);
        apply_idle();
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        wait_busy_done(n);
        check_output("reset_busy_cycles", 32'(n), 32'd16);

        // Sweep result: every entry reads zero
        read_all();
        check_output("t1_last_valid", 32'(io_rdValid), 32'd1);
        check_output("t1_last_data", 32'(io_rdData), 32'h00);

        // Full write then read
        apply_stimulus(1'b1, 2'b11, 4'd3, 8'hA5, 1'b0, 4'd0, 1'b0);
        apply_stimulus(1'b0, 2'b00, 4'd0, 8'h00, 1'b1, 4'd3, 1'b0);
        apply_idle();
        check_output("t2_data", 32'(io_rdData), 32'hA5);
        check_output("t2_valid", 32'(io_rdValid), 32'd1);
        apply_idle();
        check_output("t2_valid_pulse", 32'(io_rdValid), 32'd0);
        check_output("t2_data_hold", 32'(io_rdData), 32'hA5);

        // Lane masking
        apply_stimulus(1'b1, 2'b11, 4'd5, 8'hFF, 1'b0, 4'd0, 1'b0);
        apply_stimulus(1'b1, 2'b01, 4'd5, 8'h12, 1'b0, 4'd0, 1'b0);
        apply_stimulus(1'b0, 2'b00, 4'd0, 8'h00, 1'b1, 4'd5, 1'b0);
        apply_idle();
        check_output("t3_low_lane", 32'(io_rdData), 32'hF2);
        apply_stimulus(1'b1, 2'b00, 4'd5, 8'h12, 1'b0, 4'd0, 1'b0);
        apply_stimulus(1'b0, 2'b00, 4'd0, 8'h00, 1'b1, 4'd5, 1'b0);
        apply_idle();
        check_output("t3_mask_zero", 32'(io_rdData), 32'hF2);

        // Read during write, same address
        apply_stimulus(1'b1, 2'b10, 4'd7, 8'h3C, 1'b1, 4'd7, 1'b0);
        apply_idle();
        check_output("t4_bypass", 32'(io_rdData), BYPASS ? 32'h30 : 32'h00);

        // Fill, then a clear request with a concurrent read that must still complete
        for (int a = 0; a < DEPTH; a++)
            apply_stimulus(1'b1, 2'b11, ADDR_W'(a), DATA_W'(17 * (a + 1)), 1'b0, '0, 1'b0);
        apply_stimulus(1'b1, 2'b11, 4'd0, 8'h55, 1'b1, 4'd2, 1'b1);
        apply_random(0);
        check_output("t5_clr_cycle_read", 32'(io_rdData), 32'h33);
        check_output("t5_busy_start", 32'(io_busy), 32'd1);
        repeat (14) apply_random(4);
        apply_random(4);
        check_output("t5_busy_last", 32'(io_busy), 32'd1);
        apply_idle();
        check_output("t5_busy_end", 32'(io_busy), 32'd0);
        check_output("t5_no_valid", 32'(io_rdValid), 32'd0);
        read_all();
        check_output("t5_last_data", 32'(io_rdData), 32'h00);

        // Randomized traffic with occasional clears
        for (int c = 0; c < 800; c++) apply_random(60);
        apply_idle();
        for (int a = 0; a < DEPTH; a++)
            apply_stimulus(1'b1, 2'b11, ADDR_W'(a), 8'hC3, 1'b0, '0, 1'b0);
        apply_idle();

        // Reset in the middle of a sweep restarts it from entry 0
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (8) apply_idle();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        wait_busy_done(n);
        check_output("t6_busy_cycles", 32'(n), 32'd16);
        read_all();
        check_output("t6_last_data", 32'(io_rdData), 32'h00);
        check_output("t6_last_valid", 32'(io_rdValid), 32'd1);

        for (int c = 0; c < 300; c++) apply_random(0);
        apply_idle();
        apply_idle();

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends on its own
    initial begin
        #300000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
